instr_deserializer: RTL and testbench

- Front end of the control group: assembles byte-serial instructions from the CPU link into one parallel instruction word.
- Presents the word to the request queue via a valid/ready handshake, steering it to the AES or SHA side by opcode bit 0.
- Acts as the writer for the request queue; the AES/SHA FSMs drain the other end.
- Provides back-pressure to the CPU link while an assembled instruction waits for queue space.

---
 rtl/instr_deserializer_pkg.sv | 26 ++
 rtl/instr_deserializer_byte_shift_reg.sv | 26 ++
 rtl/instr_deserializer.sv | 141 ++++++++++++++
 tb/tb_instr_deserializer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_deserializer_pkg.sv
// Shared definitions for the instruction deserializer and the request queue:
// default geometry, FSM state codes, opcode steering and a clog2 helper.
package instr_deserializer_pkg;

    localparam int unsigned ADDRW_DEF   = 24;
    localparam int unsigned OPCODEW_DEF = 2;
    localparam int unsigned NB          = ADDRW_DEF / 8;
    localparam int unsigned INSTRW      = 3 * ADDRW_DEF + OPCODEW_DEF;

    localparam logic [1:0] ST_HDR  = 2'd0;
    localparam logic [1:0] ST_BODY = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // opcode[0] selects the destination engine
    localparam logic STEER_AES = 1'b0;
    localparam logic STEER_SHA = 1'b1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/instr_deserializer_byte_shift_reg.sv
// Byte-wide shift register, MSB first, with synchronous clear and shift enable.
module byte_shift_reg #(
    parameter int unsigned W = 72
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [7:0]   din_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    // Clear has priority over shifting a new byte into the low end
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= {data_q[W-9:0], din_i};
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/instr_deserializer.sv
// Assembles byte-serial instruction frames into a parallel word and hands it
// to the AES/SHA request queue over a valid/ready handshake.
module instr_deserializer
    import instr_deserializer_pkg::*;
#(
    parameter int unsigned ADDRW   = ADDRW_DEF,
    parameter int unsigned OPCODEW = OPCODEW_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    input  logic                       in_sof,
    output logic                       in_ready,
    input  logic                       ready_aes,
    input  logic                       ready_sha,
    output logic [3*ADDRW+OPCODEW-1:0] instr,
    output logic                       valid_out,
    output logic                       err
);

    localparam int unsigned NBL     = ADDRW / 8;
    localparam int unsigned BODYLEN = 3 * NBL;
    localparam int unsigned CNTW    = clog2(BODYLEN);
    localparam int unsigned SRW     = 3 * ADDRW;
    localparam int unsigned IW      = SRW + OPCODEW;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BODYLEN - 1);

    logic [1:0]         state_q, state_d;
    logic [OPCODEW-1:0] opcode_q, opcode_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]      instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;

    logic               sr_clr, sr_en;
    logic [SRW-1:0]     sr_q;
    logic               accept, hdr_ok, sel_ready;

    byte_shift_reg #(
        .W(SRW)
    ) u_addr_sr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (sr_clr),
        .en_i  (sr_en),
        .din_i (in_data),
        .q_o   (sr_q)
    );

    assign in_ready  = (state_q != ST_HOLD) && !rst;
    assign accept    = in_valid && in_ready;
    assign hdr_ok    = in_sof && ((in_data >> OPCODEW) == 8'd0);
    assign sel_ready = (opcode_q[0] == STEER_SHA) ? ready_sha : ready_aes;

    // Next-state logic for framing, body collection and the queue handshake
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        cnt_d    = cnt_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        err_d    = 1'b0;
        sr_clr   = 1'b0;
        sr_en    = 1'b0;
        case (state_q)
            ST_HDR: begin
                if (accept) begin
                    if (hdr_ok) begin
                        opcode_d = in_data[OPCODEW-1:0];
                        cnt_d    = '0;
                        sr_clr   = 1'b1;
                        state_d  = ST_BODY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_BODY: begin
                if (accept) begin
                    if (in_sof) begin
                        // Abandon the partial frame; the byte is re-judged as a header
                        err_d = 1'b1;
                        cnt_d = '0;
                        if (hdr_ok) begin
                            opcode_d = in_data[OPCODEW-1:0];
                            sr_clr   = 1'b1;
                        end else begin
                            state_d = ST_HDR;
                        end
                    end else begin
                        sr_en = 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            // Final byte bypasses the shift register straight into the word
                            instr_d = {opcode_q, sr_q[SRW-9:0], in_data};
                            valid_d = 1'b1;
                            cnt_d   = '0;
                            state_d = ST_HOLD;
                        end else begin
                            cnt_d = cnt_q + CNTW'(1);
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (sel_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_HDR;
                end
            end
            default: begin
                state_d = ST_HDR;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_HDR;
            opcode_q <= '0;
            cnt_q    <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            cnt_q    <= cnt_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign instr     = instr_q;
    assign valid_out = valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instr_deserializer.sv
// Directed bench for instr_deserializer at default geometry (74-bit word).
module tb_instr_deserializer;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_sof;
    logic        in_ready;
    logic        ready_aes;
    logic        ready_sha;
    logic [73:0] instr;
    logic        valid_out;
    logic        err;

    int checks;
    int errors;
    int err_cnt;
    int base;
    logic [73:0] held;

    instr_deserializer #(
        .ADDRW(24),
        .OPCODEW(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_ready  (in_ready),
        .ready_aes (ready_aes),
        .ready_sha (ready_sha),
        .instr     (instr),
        .valid_out (valid_out),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count err pulses mid-cycle
    always @(negedge clk) begin
        if (err === 1'b1) err_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic sof);
        int unsigned n;
        in_valid = 1'b1;
        in_data  = b;
        in_sof   = sof;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout observed=in_ready_low expected=in_ready_high");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_body(input logic [23:0] k, input logic [23:0] t,
                             input logic [23:0] d, input bit gaps);
        logic [71:0] body;
        body = {k, t, d};
        for (int i = 0; i < 9; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            send_byte(body[71-8*i -: 8], 1'b0);
        end
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [23:0] k,
                              input logic [23:0] t, input logic [23:0] d, input bit gaps);
        send_byte(hdr, 1'b1);
        send_body(k, t, d, gaps);
    endtask

    initial begin
        checks = 0; errors = 0; err_cnt = 0;
        rst = 1'b1; in_data = '0; in_valid = 1'b0; in_sof = 1'b0;
        ready_aes = 1'b0; ready_sha = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_instr", instr, 74'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        // Clean AES frame
        ready_aes = 1'b1;
        base = err_cnt;
        send_frame(8'h00, 24'h112233, 24'h445566, 24'h778899, 1'b0);
        chk("aes_valid", valid_out, 1'b1);
        chk("aes_instr", instr, {2'b00, 24'h112233, 24'h445566, 24'h778899});
        chk("aes_hold_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        chk("aes_valid_drop", valid_out, 1'b0);
        chk("aes_in_ready_back", in_ready, 1'b1);
        chk("aes_no_err", err_cnt, base);

        // SHA frame stalled for 5 cycles; AES ready must not release it
        ready_sha = 1'b0;
        ready_aes = 1'b1;
        send_frame(8'h01, 24'hA1B2C3, 24'hD4E5F6, 24'h0718293, 1'b0);
        held = {2'b01, 24'hA1B2C3, 24'hD4E5F6, 24'h718293};
        chk("sha_valid0", valid_out, 1'b1);
        chk("sha_instr0", instr, held);
        chk("sha_in_ready0", in_ready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("sha_valid_hold", valid_out, 1'b1);
            chk("sha_instr_hold", instr, held);
            chk("sha_in_ready_hold", in_ready, 1'b0);
        end
        ready_sha = 1'b1;
        @(posedge clk); #1;
        chk("sha_released", valid_out, 1'b0);
        chk("sha_in_ready_back", in_ready, 1'b1);
        ready_sha = 1'b0;

        // Reserved header bit, then a non-SOF byte in HDR: back-to-back err pulses
        base = err_cnt;
        send_byte(8'h04, 1'b1);
        chk("resv_err", err, 1'b1);
        chk("resv_no_valid", valid_out, 1'b0);
        send_byte(8'h33, 1'b0);
        chk("nosof_err", err, 1'b1);
        @(posedge clk); #1;
        chk("err_cleared", err, 1'b0);
        chk("err_pulse_count", err_cnt, base + 2);
        send_frame(8'h00, 24'hA1A2A3, 24'hB1B2B3, 24'hC1C2C3, 1'b0);
        chk("after_err_valid", valid_out, 1'b1);
        chk("after_err_instr", instr, {2'b00, 24'hA1A2A3, 24'hB1B2B3, 24'hC1C2C3});
        @(posedge clk); #1;
        chk("after_err_drop", valid_out, 1'b0);

        // SOF on the 5th byte restarts the frame
        send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'h02, 1'b1);
        chk("midsof_err", err, 1'b1);
        chk("midsof_no_valid", valid_out, 1'b0);
        send_body(24'h010203, 24'h040506, 24'h070809, 1'b0);
        chk("midsof_valid", valid_out, 1'b1);
        chk("midsof_instr", instr, {2'b10, 24'h010203, 24'h040506, 24'h070809});
        @(posedge clk); #1;
        chk("midsof_drop", valid_out, 1'b0);

        // Reset in HOLD, then mid-BODY
        ready_aes = 1'b0;
        send_frame(8'h00, 24'h111111, 24'h222222, 24'h333333, 1'b0);
        chk("hold_before_rst", valid_out, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_hold_valid", valid_out, 1'b0);
        chk("rst_hold_instr", instr, 74'h0);
        chk("rst_hold_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_hold_ready_back", in_ready, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hBE, 1'b0);
        send_byte(8'hEF, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_body_valid", valid_out, 1'b0);
        rst = 1'b0;
        #1;
        ready_aes = 1'b1;
        send_frame(8'h00, 24'h0A0B0C, 24'h0D0E0F, 24'h101112, 1'b0);
        chk("post_rst_valid", valid_out, 1'b1);
        chk("post_rst_instr", instr, {2'b00, 24'h0A0B0C, 24'h0D0E0F, 24'h101112});
        @(posedge clk); #1;
        chk("post_rst_drop", valid_out, 1'b0);

        // Three frames with random gaps, alternating destination
        base = err_cnt;
        ready_aes = 1'b1; ready_sha = 1'b0;
        send_frame(8'h00, 24'h123456, 24'h789ABC, 24'hDEF012, 1'b1);
        chk("gap0_valid", valid_out, 1'b1);
        chk("gap0_instr", instr, {2'b00, 24'h123456, 24'h789ABC, 24'hDEF012});
        @(posedge clk); #1;
        chk("gap0_routed_aes", valid_out, 1'b0);
        ready_aes = 1'b0; ready_sha = 1'b1;
        send_frame(8'h01, 24'h345678, 24'h9ABCDE, 24'hF01234, 1'b1);
        chk("gap1_valid", valid_out, 1'b1);
        chk("gap1_instr", instr, {2'b01, 24'h345678, 24'h9ABCDE, 24'hF01234});
        @(posedge clk); #1;
        chk("gap1_routed_sha", valid_out, 1'b0);
        ready_aes = 1'b1; ready_sha = 1'b0;
        send_frame(8'h00, 24'h55AA55, 24'hAA55AA, 24'h0F0F0F, 1'b1);
        chk("gap2_valid", valid_out, 1'b1);
        chk("gap2_instr", instr, {2'b00, 24'h55AA55, 24'hAA55AA, 24'h0F0F0F});
        @(posedge clk); #1;
        chk("gap2_routed_aes", valid_out, 1'b0);
        chk("gap_no_err", err_cnt, base);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
